// File: rtl/snake_step_ctrl_pkg.sv
// Shared definitions for the snake step sequencer.
//   dir_e     : direction codes carried on the key and step buses
//   state_e   : game state encoding, also driven on the state output
//   dir_rev() : the opposite direction (codes are arranged so xor 2 reverses)
package snake_step_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int TICK_DIV_DEF = 25_000_000;

  function automatic logic [1:0] dir_rev(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/snake_step_ctrl_dir_queue.sv
// dir_queue: per-player 2-entry direction FIFO with a legality filter.
//   clk, rst     : clock, async active-low reset
//   flush        : empty the queue (game start)
//   pop          : step issued; head moves to the step direction (no-op if empty)
//   push,push_dir: key event; accepted only if not a duplicate/reversal of the
//                  reference direction and the queue has room after the pop
//   cur_dir      : direction currently applied to the core
//   head         : oldest queued direction
//   not_empty    : queue holds at least one entry
module dir_queue
  import snake_step_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       pop,
  input  logic       push,
  input  logic [1:0] push_dir,
  input  logic [1:0] cur_dir,
  output logic [1:0] head,
  output logic       not_empty
);

  logic [1:0][1:0] q;
  logic [1:0]      cnt, cnt_post;
  logic [1:0]      ref_dir;
  logic            pop_eff, full, accept, wr_idx;

  assign pop_eff  = pop && (cnt != 2'd0);
  assign cnt_post = cnt - {1'b0, pop_eff};

  // The tail survives a pop when two entries are held, and when one entry is
  // popped it becomes the new cur_dir, so the post-pop reference equals the
  // pre-pop tail whenever the queue is non-empty.
  assign ref_dir = (cnt == 2'd2) ? q[1] : (cnt == 2'd1) ? q[0] : cur_dir;
  assign full    = (cnt == 2'd2) && !pop_eff;
  assign accept  = push && !full && (push_dir != ref_dir)
                   && (push_dir != dir_rev(ref_dir));
  assign wr_idx  = cnt_post[0];

  assign head      = q[0];
  assign not_empty = (cnt != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0;
      q   <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      if (pop_eff) q[0] <= q[1];
      // Later assignment wins when a push lands in the slot just vacated.
      if (accept) q[wr_idx] <= push_dir;
      cnt <= cnt_post + {1'b0, accept};
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game sequencer between key decode and the snake core.
//   clk, rst              : clock, async active-low reset
//   p1_valid/p1_dir       : player-1 direction key pulse
//   p2_valid/p2_dir       : player-2 direction key pulse
//   start_key, pause_key  : start/restart and pause-toggle pulses
//   game_over             : level from the core
//   step_done             : core has applied the requested step
//   step                  : step request, held until step_done
//   step_dir1, step_dir2  : directions for the current step
//   core_clear            : one-cycle core re-initialise pulse
//   state                 : IDLE/RUN/PAUSE/OVER
module snake_step_ctrl
  import snake_step_ctrl_pkg::*;
#(
  parameter int         tick_div  = TICK_DIV_DEF,
  parameter logic [1:0] dir_init1 = 2'd1,
  parameter logic [1:0] dir_init2 = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_valid,
  input  logic [1:0] p1_dir,
  input  logic       p2_valid,
  input  logic [1:0] p2_dir,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       game_over,
  input  logic       step_done,
  output logic       step,
  output logic [1:0] step_dir1,
  output logic [1:0] step_dir2,
  output logic       core_clear,
  output logic [1:0] state
);

  localparam int NP = 2;
  localparam int CW = $clog2(tick_div);
  localparam logic [CW-1:0] CNT_MAX = CW'(tick_div - 1);

  state_e             st;
  logic [CW-1:0]      cnt;
  logic [NP-1:0]      key_vld, q_ne;
  logic [NP-1:0][1:0] key_dir, q_head, cur_dir;
  logic               clear, tick_fire;

  // Restart is honoured only from IDLE or OVER.
  assign clear     = start_key && (st == ST_IDLE || st == ST_OVER);
  // No new step once the core reports game over.
  assign tick_fire = (st == ST_RUN) && !step && !game_over && (cnt == CNT_MAX);

  assign key_vld = {p2_valid, p1_valid} & {NP{st == ST_RUN}};
  assign key_dir = {p2_dir, p1_dir};

  for (genvar i = 0; i < NP; i++) begin : g_q
    dir_queue u_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear),
      .pop       (tick_fire),
      .push      (key_vld[i]),
      .push_dir  (key_dir[i]),
      .cur_dir   (cur_dir[i]),
      .head      (q_head[i]),
      .not_empty (q_ne[i])
    );
  end

  assign step_dir1 = cur_dir[0];
  assign step_dir2 = cur_dir[1];
  assign state     = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= ST_IDLE;
      step       <= 1'b0;
      core_clear <= 1'b0;
      cnt        <= '0;
      cur_dir    <= {dir_init2, dir_init1};
    end else begin
      core_clear <= 1'b0;
      // An outstanding request is released by its ack in any state.
      if (step && step_done) step <= 1'b0;

      unique case (st)
        ST_IDLE, ST_OVER: begin
          if (clear) begin
            core_clear <= 1'b1;
            cnt        <= '0;
            cur_dir    <= {dir_init2, dir_init1};
            st         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (game_over)      st <= ST_OVER;
          else if (pause_key) st <= ST_PAUSE;
          if (tick_fire) begin
            cnt  <= '0;
            step <= 1'b1;
            for (int i = 0; i < NP; i++)
              if (q_ne[i]) cur_dir[i] <= q_head[i];
          end else if (!step) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (game_over)      st <= ST_OVER;
          else if (pause_key) st <= ST_RUN;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
module tb_snake_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p1_valid = 1'b0, p2_valid = 1'b0;
  logic [1:0] p1_dir = 2'd0, p2_dir = 2'd0;
  logic       start_key = 1'b0, pause_key = 1'b0, game_over = 1'b0, step_done = 1'b0;
  logic       step, core_clear;
  logic [1:0] step_dir1, step_dir2, state;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];   // expected {step_dir1, step_dir2} per step
  logic [3:0] exp;
  int lat;

  snake_step_ctrl #(.tick_div(8), .dir_init1(2'd1), .dir_init2(2'd3)) dut (
    .clk(clk), .rst(rst),
    .p1_valid(p1_valid), .p1_dir(p1_dir),
    .p2_valid(p2_valid), .p2_dir(p2_dir),
    .start_key(start_key), .pause_key(pause_key),
    .game_over(game_over), .step_done(step_done),
    .step(step), .step_dir1(step_dir1), .step_dir2(step_dir2),
    .core_clear(core_clear), .state(state)
  );

  always #5 clk = ~clk;

  // ---- stimulus helpers (no checking) ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start_key = 1'b1; tick(); start_key = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_key = 1'b1; tick(); pause_key = 1'b0;
  endtask

  task automatic ack();
    step_done = 1'b1; tick(); step_done = 1'b0;
  endtask

  task automatic key(input logic v1, input logic [1:0] d1,
                     input logic v2, input logic [1:0] d2);
    p1_valid = v1; p1_dir = d1; p2_valid = v2; p2_dir = d2;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
  endtask

  // Edges until step is seen high; 40 means it never came.
  task automatic wait_step(output int n);
    n = 0;
    do begin tick(); n++; end while (!step && n < 40);
  endtask

  function automatic logic [3:0] pop_exp();
    if (exp_q.size() == 0) return 4'bxxxx;
    return exp_q.pop_front();
  endfunction

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step); end
    n_chk++; if (core_clear !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b want 0", core_clear); end
    n_chk++; if ({step_dir1, step_dir2} !== 4'b01_11) begin n_fail++; $display("FAIL reset_dirs: got %0d/%0d want 1/3", step_dir1, step_dir2); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_start();
    exp_q.push_back({2'd1, 2'd3});
    pulse_start();
    n_chk++; if (core_clear !== 1'b1) begin n_fail++; $display("FAIL start_clear: got %b want 1", core_clear); end
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
    tick();
    n_chk++; if (core_clear !== 1'b0) begin n_fail++; $display("FAIL start_clear_1cyc: got %b want 0", core_clear); end
    wait_step(lat);
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL start_first_step_lat: got %0d want 7", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL start_dirs: got %h want %h", {step_dir1, step_dir2}, exp); end
    ack();
    n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL start_ack: got %b want 0", step); end
  endtask

  task automatic test_queue_order();
    key(1'b1, 2'd0, 1'b1, 2'd2); exp_q.push_back({2'd0, 2'd2});
    key(1'b1, 2'd3, 1'b1, 2'd1); exp_q.push_back({2'd3, 2'd1});
    wait_step(lat);
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL order_lat0: got %0d want 6", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL order_step0: got %h want %h", {step_dir1, step_dir2}, exp); end
    ack();
    wait_step(lat);
    n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL order_lat1: got %0d want 8", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL order_step1: got %h want %h", {step_dir1, step_dir2}, exp); end
    ack();
  endtask

  // Current dirs are 3/1 here.
  task automatic test_filter();
    key(1'b1, 2'd1, 1'b0, 2'd0);  // reverse of 3: rejected
    key(1'b1, 2'd3, 1'b0, 2'd0);  // duplicate: rejected
    key(1'b1, 2'd0, 1'b0, 2'd0);  // accepted -> [0]
    key(1'b1, 2'd2, 1'b0, 2'd0);  // reverse of tail 0: rejected
    key(1'b1, 2'd1, 1'b0, 2'd0);  // accepted -> [0,1]
    key(1'b1, 2'd2, 1'b0, 2'd0);  // legal but queue full: dropped
    exp_q.push_back({2'd0, 2'd1});
    exp_q.push_back({2'd1, 2'd1});
    exp_q.push_back({2'd1, 2'd1});
    wait_step(lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL filter_lat0: got %0d want 2", lat); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        wait_step(lat);
        n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL filter_lat%0d: got %0d want 8", i, lat); end
      end
      exp = pop_exp();
      n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL filter_step%0d: got %h want %h", i, {step_dir1, step_dir2}, exp); end
      ack();
    end
  endtask

  task automatic test_stall();
    exp_q.push_back({2'd1, 2'd1});
    wait_step(lat);
    n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL stall_lat0: got %0d want 8", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL stall_dirs: got %h want %h", {step_dir1, step_dir2}, exp); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if ({step, step_dir1, step_dir2} !== {1'b1, exp}) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, {step, step_dir1, step_dir2}, {1'b1, exp}); end
    end
    ack();
    n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL stall_ack: got %b want 0", step); end
    exp_q.push_back({2'd1, 2'd1});
    wait_step(lat);
    n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL stall_after_ack_lat: got %0d want 8", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL stall_next_dirs: got %h want %h", {step_dir1, step_dir2}, exp); end
    ack();
  endtask

  task automatic test_pause();
    bit saw;
    exp_q.push_back({2'd1, 2'd1});
    wait_step(lat);
    exp = pop_exp();
    n_chk++; if ({lat, step_dir1, step_dir2} !== {8, exp}) begin n_fail++; $display("FAIL pause_pre_step: got lat %0d dirs %h want lat 8 dirs %h", lat, {step_dir1, step_dir2}, exp); end
    pulse_pause();
    n_chk++; if ({state, step} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL pause_enter: got state %0d step %b want 2/1", state, step); end
    key(1'b1, 2'd0, 1'b0, 2'd0);  // ignored while paused
    ack();
    n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL pause_ack: got %b want 0", step); end
    saw = 1'b0;
    repeat (20) begin tick(); if (step) saw = 1'b1; end
    n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL pause_no_step: got %b want 0", saw); end
    pulse_pause();
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL pause_resume: got %0d want 1", state); end
    // Run 4 counts, pause for a while, then expect the remaining 4.
    repeat (3) tick();
    pulse_pause();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_mid: got %0d want 2", state); end
    saw = 1'b0;
    repeat (10) begin tick(); if (step) saw = 1'b1; end
    n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL pause_mid_no_step: got %b want 0", saw); end
    pulse_pause();
    exp_q.push_back({2'd1, 2'd1});
    wait_step(lat);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL pause_remaining_lat: got %0d want 4", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL pause_resume_dirs: got %h want %h", {step_dir1, step_dir2}, exp); end
    ack();
  endtask

  task automatic test_over();
    bit saw;
    key(1'b1, 2'd0, 1'b0, 2'd0);  // queued, must be flushed by restart
    game_over = 1'b1; pause_key = 1'b1;
    tick();
    pause_key = 1'b0;
    n_chk++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_priority: got %0d want 3", state); end
    pulse_pause();  // ignored in OVER
    saw = 1'b0;
    repeat (12) begin tick(); if (step || state != 2'd3) saw = 1'b1; end
    n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL over_stuck: got %b want 0", saw); end
    game_over = 1'b0;
    exp_q.push_back({2'd1, 2'd3});
    pulse_start();
    n_chk++; if ({core_clear, state} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL over_restart: got clear %b state %0d want 1/1", core_clear, state); end
    n_chk++; if ({step_dir1, step_dir2} !== 4'b01_11) begin n_fail++; $display("FAIL over_restart_dirs: got %0d/%0d want 1/3", step_dir1, step_dir2); end
    tick();
    wait_step(lat);
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL over_first_step_lat: got %0d want 7", lat); end
    exp = pop_exp();
    n_chk++; if ({step_dir1, step_dir2} !== exp) begin n_fail++; $display("FAIL over_flush_dirs: got %h want %h", {step_dir1, step_dir2}, exp); end
  endtask

  // Step is outstanding on entry.
  task automatic test_reset_mid_step();
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({step, state} !== {1'b0, 2'd0}) begin n_fail++; $display("FAIL async_reset: got step %b state %0d want 0/0", step, state); end
    tick();
    rst = 1'b1;
    n_chk++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_queue_order();
    test_filter();
    test_stall();
    test_pause();
    test_over();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
